vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Pixel-clock-divided VGA raster timing generator: hs/vs/blank/sync plus
// coordinates, all registered together so every output refers to the same pixel.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 256,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 41,
  parameter int   H_BP     = 20,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   PIX_DIV  = 1,
  parameter int   Y_SHIFT  = 1,
  parameter int   CW       = 11
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          pix_ce,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [4:0]    DIV_LAST = 5'(PIX_DIV - 1);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must all be non-zero");
  end
  if (H_TOT >= (1 << CW) || V_TOT >= (1 << CW)) begin : g_bad_total
    $error("vga_timing_gen: H_TOT/V_TOT do not fit in CW bits");
  end
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be in 1..16");
  end

  function automatic logic h_pulse(input logic [CW-1:0] h);
    return (h >= HS_START) && (h < HS_END);
  endfunction

  function automatic logic v_pulse(input logic [CW-1:0] v);
    return (v >= VS_START) && (v < VS_END);
  endfunction

  logic          run;
  logic [4:0]    div;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;

  // Reset release is taken up on the first enabled clock edge, so counting
  // starts from a clean, clock-aligned point.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)  run <= 1'b0;
    else if (en) run <= 1'b1;
  end

  assign pix_ce = en & run & (div == DIV_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)         div <= '0;
    else if (en && run) div <= (div == DIV_LAST) ? 5'd0 : div + 5'd1;
  end

  always_comb begin
    h_wrap = (hcount == H_LAST);
    h_nxt  = h_wrap ? '0 : hcount + CW'(1);
    v_nxt  = vcount;
    if (h_wrap) v_nxt = (vcount == V_LAST) ? '0 : vcount + CW'(1);
  end

  // Outputs are derived from the next counter values so they land on the
  // same edge as the counters themselves.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hs          <= ~H_POL;
      vs          <= ~V_POL;
      blank       <= 1'b1;
      sync        <= 1'b1;
      DrawX       <= '0;
      DrawY       <= '0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      vblank      <= 1'b0;
    end else if (pix_ce) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hs          <= h_pulse(h_nxt) ? H_POL : ~H_POL;
      vs          <= v_pulse(v_nxt) ? V_POL : ~V_POL;
      blank       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      sync        <= ~(h_pulse(h_nxt) | v_pulse(v_nxt));
      DrawX       <= h_nxt;
      DrawY       <= v_nxt >> Y_SHIFT;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      vblank      <= (v_nxt >= V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen on a small raster with a
// clock divider, inverted hsync polarity and line doubling.
module tb_vga_timing_gen;

  localparam int   HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int   VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   PD = 3;
  localparam int   YS = 1;
  localparam logic HP = 1'b1;
  localparam logic VP = 1'b0;
  localparam int   CW = 8;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          blank;
    logic          sync;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          pix_ce;
    logic          ls;
    logic          fs;
    logic          vb;
  } obs_t;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          en = 1'b0;
  logic          hs, vs, blank, sync, pix_ce, line_start, frame_start, vblank;
  logic [CW-1:0] DrawX, DrawY;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .PIX_DIV(PD), .Y_SHIFT(YS), .CW(CW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .en(en),
    .hs(hs), .vs(vs), .blank(blank), .sync(sync),
    .DrawX(DrawX), .DrawY(DrawY), .pix_ce(pix_ce),
    .line_start(line_start), .frame_start(frame_start), .vblank(vblank)
  );

  always #5 Clk = ~Clk;

  obs_t act;
  assign act = '{hs, vs, blank, sync, DrawX, DrawY, pix_ce, line_start, frame_start, vblank};

  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  bit   armed = 1'b0;

  // Reference state: enabled clocks counted since counting began.
  bit m_run = 1'b0;
  int ecount = 0;

  function automatic int pix_idx();
    return ecount / PD;
  endfunction
  function automatic int cur_h();
    return pix_idx() % HT;
  endfunction
  function automatic int cur_v();
    return (pix_idx() / HT) % VT;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    int   h, v;
    bit   hp, vp;
    h = cur_h();
    v = cur_v();
    hp = (h >= HA + HF) && (h < HA + HF + HS);
    vp = (v >= VA + VF) && (v < VA + VF + VS);
    e.hs     = hp ? HP : ~HP;
    e.vs     = vp ? VP : ~VP;
    e.blank  = (h < HA) && (v < VA);
    e.sync   = !(hp || vp);
    e.x      = CW'(h);
    e.y      = CW'(v >> YS);
    e.pix_ce = Reset && en && m_run && ((ecount % PD) == PD - 1);
    e.ls     = (h == 0);
    e.fs     = (h == 0) && (v == 0);
    e.vb     = (v >= VA);
    return e;
  endfunction

  // One clock: advance the model on the edge, then apply new inputs just after it.
  task automatic cycle(input logic en_v, input logic rst_v);
    @(posedge Clk);
    if (Reset) begin
      if (!m_run) begin
        if (en) m_run = 1'b1;
      end else if (en) begin
        ecount++;
      end
    end
    #1;
    en = en_v;
    Reset = rst_v;
    if (!Reset) begin
      m_run = 1'b0;
      ecount = 0;
    end
    exp_q.push_back(model_out());
    armed = 1'b1;
  endtask

  task automatic check_reset_state(input string name);
    obs_t r;
    r = '{~HP, ~VP, 1'b1, 1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (act !== r) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, r);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge Clk);
      if (armed) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty t=%0t actual=%h required=<entry>", $time, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, e);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    // Initial reset and release with en high.
    repeat (3) cycle(1'b1, 1'b0);
    @(negedge Clk); #1;
    check_reset_state("reset_state");
    cycle(1'b1, 1'b1);

    // More than one full frame with en continuously high.
    repeat (HT * VT * PD + 40) cycle(1'b1, 1'b1);

    // Random enable gaps.
    repeat (1500) cycle(($urandom_range(0, 3) != 0), 1'b1);

    // Freeze inside the hsync pulse, then resume.
    guard = 0;
    while (!(cur_h() == HA + HF + 1 && (ecount % PD) == 0) && guard < 4000) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    checks++;
    if (guard >= 4000) begin
      failures++;
      $display("FAIL reach_hold_point actual=timeout required=h%0d", HA + HF + 1);
    end
    repeat (40) cycle(1'b0, 1'b1);
    repeat (PD * 4) cycle(1'b1, 1'b1);

    // Asynchronous reset mid-frame, observed before any further edge.
    guard = 0;
    while (!(cur_h() == 10 && cur_v() == 5) && guard < 4000) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    checks++;
    if (guard >= 4000) begin
      failures++;
      $display("FAIL reach_reset_point actual=timeout required=h10_v5");
    end
    cycle(1'b1, 1'b0);
    @(negedge Clk); #1;
    check_reset_state("midframe_reset");
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);

    // Restart from frame start with random enable.
    repeat (HT * VT * PD + 20) cycle(($urandom_range(0, 7) != 0), 1'b1);

    @(negedge Clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
